// File: rtl/des_stream_sequencer.sv
// Credit-limited scheduler: streams N blocks from the input SRAM through the DES core into the output SRAM.
// Define DES_SEQ_PERF_EN to add the cycle_count performance port.
module des_stream_sequencer #(
  parameter int ADDRSIZE     = 14,
  parameter int SRAMWIDTH    = 64,
  parameter int RD_LATENCY   = 2,
  parameter int MAX_INFLIGHT = 4,
  parameter int BASE_ADDR    = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [ADDRSIZE-1:0]  num_blocks,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [ADDRSIZE-1:0]  blocks_written,
  output logic [ADDRSIZE-1:0]  in_addr,
  output logic                 in_rden,
  input  logic [SRAMWIDTH-1:0] in_q,
  output logic [SRAMWIDTH-1:0] des_data_in,
  output logic                 des_valid_in,
  input  logic [SRAMWIDTH-1:0] des_data_out,
  input  logic                 des_valid_out,
  output logic [ADDRSIZE-1:0]  out_addr,
  output logic                 out_wren,
  output logic [SRAMWIDTH-1:0] out_data
`ifdef DES_SEQ_PERF_EN
  ,
  output logic [31:0]          cycle_count
`endif
);

  localparam int CW = 5;
  localparam logic [CW-1:0]       MAX_C  = CW'(MAX_INFLIGHT);
  localparam logic [ADDRSIZE-1:0] BASE_C = ADDRSIZE'(BASE_ADDR);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                state_r;
  state_t                state_next_s;
  logic                  busy_r;
  logic                  done_r;
  logic                  busy_s;
  logic                  done_s;
  logic                  err_r;
  logic [ADDRSIZE-1:0]   n_r;
  logic [ADDRSIZE-1:0]   issued_r;
  logic [ADDRSIZE-1:0]   in_addr_r;
  logic [ADDRSIZE-1:0]   out_addr_r;
  logic [ADDRSIZE-1:0]   blocks_written_r;
  logic [CW-1:0]         inflight_r;
  logic [CW-1:0]         pipe_cnt_r;
  logic [CW-1:0]         occ_s;
  logic [RD_LATENCY-1:0] tag_r;
  logic                  in_rden_r;
  logic                  des_valid_in_r;
  logic                  out_wren_r;
  logic [SRAMWIDTH-1:0]  des_data_in_r;
  logic [SRAMWIDTH-1:0]  out_data_r;
  logic                  start_ok_s;
  logic                  active_s;
  logic                  issue_s;
  logic                  tag_exit_s;
  logic                  dvo_ok_s;
  logic                  spurious_s;

  // pipe_cnt counts reads decided but not yet handed to DES, so occupancy never dips during hand-over
  assign start_ok_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign active_s   = (state_r == ST_RUN) || (state_r == ST_DRAIN);
  assign occ_s      = inflight_r + pipe_cnt_r;
  assign issue_s    = (state_r == ST_RUN) && !abort && (issued_r < n_r) && (occ_s < MAX_C);
  assign tag_exit_s = tag_r[RD_LATENCY-1];
  assign dvo_ok_s   = des_valid_out && active_s && (inflight_r != {CW{1'b0}});
  assign spurious_s = des_valid_out && active_s && (inflight_r == {CW{1'b0}});

  // State register with registered status flags
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next_s = (num_blocks == {ADDRSIZE{1'b0}}) ? ST_DONE : ST_RUN;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_RUN: begin
        if ((issued_r == n_r) || abort) begin
          state_next_s = ST_DRAIN;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if ((inflight_r == {CW{1'b0}}) && (pipe_cnt_r == {CW{1'b0}})) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Status decode of the upcoming state, registered alongside it
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_next_s)
      ST_RUN, ST_DRAIN: busy_s = 1'b1;
      ST_DONE:          done_s = 1'b1;
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  // Read issue: job length, issue count, input address, rden tag pipe
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      n_r        <= {ADDRSIZE{1'b0}};
      issued_r   <= {ADDRSIZE{1'b0}};
      in_addr_r  <= BASE_C;
      in_rden_r  <= 1'b0;
      tag_r      <= {RD_LATENCY{1'b0}};
      pipe_cnt_r <= {CW{1'b0}};
    end else begin
      in_rden_r <= issue_s;
      tag_r[0]  <= in_rden_r;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_r[i] <= tag_r[i-1];
      end
      if (start_ok_s) begin
        n_r        <= num_blocks;
        issued_r   <= {ADDRSIZE{1'b0}};
        in_addr_r  <= BASE_C;
        pipe_cnt_r <= {CW{1'b0}};
      end else begin
        issued_r  <= issued_r + ADDRSIZE'(issue_s);
        in_addr_r <= in_addr_r + ADDRSIZE'(in_rden_r);
        case ({issue_s, tag_exit_s})
          2'b10:   pipe_cnt_r <= pipe_cnt_r + {{(CW-1){1'b0}}, 1'b1};
          2'b01:   pipe_cnt_r <= pipe_cnt_r - {{(CW-1){1'b0}}, 1'b1};
          default: pipe_cnt_r <= pipe_cnt_r;
        endcase
      end
    end
  end

  // DES hand-off and in-flight credit accounting
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      des_data_in_r  <= {SRAMWIDTH{1'b0}};
      des_valid_in_r <= 1'b0;
      inflight_r     <= {CW{1'b0}};
    end else begin
      des_valid_in_r <= tag_exit_s;
      if (tag_exit_s) begin
        des_data_in_r <= in_q;
      end
      if (start_ok_s) begin
        inflight_r <= {CW{1'b0}};
      end else begin
        case ({tag_exit_s, dvo_ok_s})
          2'b10:   inflight_r <= inflight_r + {{(CW-1){1'b0}}, 1'b1};
          2'b01:   inflight_r <= inflight_r - {{(CW-1){1'b0}}, 1'b1};
          default: inflight_r <= inflight_r;
        endcase
      end
    end
  end

  // Result write-back and sticky error; addresses advance after each completed write
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_wren_r       <= 1'b0;
      out_data_r       <= {SRAMWIDTH{1'b0}};
      out_addr_r       <= BASE_C;
      blocks_written_r <= {ADDRSIZE{1'b0}};
      err_r            <= 1'b0;
    end else begin
      out_wren_r <= dvo_ok_s;
      err_r      <= err_r | spurious_s;
      if (dvo_ok_s) begin
        out_data_r <= des_data_out;
      end
      if (start_ok_s) begin
        out_addr_r       <= BASE_C;
        blocks_written_r <= {ADDRSIZE{1'b0}};
      end else begin
        out_addr_r       <= out_addr_r + ADDRSIZE'(out_wren_r);
        blocks_written_r <= blocks_written_r + ADDRSIZE'(out_wren_r);
      end
    end
  end

`ifdef DES_SEQ_PERF_EN
  logic [31:0] cycle_cnt_r;

  // Saturating job cycle counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cycle_cnt_r <= 32'd0;
    end else if (start_ok_s) begin
      cycle_cnt_r <= 32'd0;
    end else if (active_s && (cycle_cnt_r != 32'hFFFF_FFFF)) begin
      cycle_cnt_r <= cycle_cnt_r + 32'd1;
    end else begin
      cycle_cnt_r <= cycle_cnt_r;
    end
  end

  assign cycle_count = cycle_cnt_r;
`endif

  assign busy           = busy_r;
  assign done           = done_r;
  assign err            = err_r;
  assign blocks_written = blocks_written_r;
  assign in_addr        = in_addr_r;
  assign in_rden        = in_rden_r;
  assign des_data_in    = des_data_in_r;
  assign des_valid_in   = des_valid_in_r;
  assign out_addr       = out_addr_r;
  assign out_wren       = out_wren_r;
  assign out_data       = out_data_r;

endmodule
